// File: rtl/result_queues_stage_pkg.sv
// result_queues_stage_pkg
//   Shared types for the lane writeback stage: VRF word address, result word,
//   byte strobes, instruction id, the result source enumeration and the
//   buffered result entry. Also holds the wrap-around increment used by the
//   round-robin arbiter.
package result_queues_stage_pkg;

  localparam int unsigned ELEN        = 64;
  localparam int unsigned VaddrW      = 16;
  localparam int unsigned NrVInsn     = 8;
  localparam int unsigned NrResultSrc = 5;
  localparam int unsigned SrcW        = 3;

  typedef logic [VaddrW-1:0]          vaddr_t;
  typedef logic [ELEN-1:0]            elen_t;
  typedef logic [ELEN/8-1:0]          strb_t;
  typedef logic [$clog2(NrVInsn)-1:0] vid_t;

  typedef enum logic [SrcW-1:0] {
    ResAlu   = 3'd0,
    ResMfpu  = 3'd1,
    ResVldu  = 3'd2,
    ResSldu  = 3'd3,
    ResMasku = 3'd4
  } result_src_e;

  typedef struct packed {
    vaddr_t addr;
    elen_t  wdata;
    strb_t  be;
    vid_t   id;
  } result_entry_t;

  // Next source index, wrapping after the last source.
  function automatic logic [SrcW-1:0] src_wrap_inc(input logic [SrcW-1:0] s);
    return (s == SrcW'(NrResultSrc - 1)) ? '0 : s + SrcW'(1);
  endfunction

endpackage

// File: rtl/result_queues_stage_fifo.sv
// result_queues_stage_fifo
//   Per-source result FIFO (fifo_v3-style, no fall-through).
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     push_i, data_i  write side; ignored while full
//     pop_i,  data_o  read side; data_o is the head entry, pop ignored while empty
//     full_o, empty_o occupancy flags
module result_queues_stage_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  dtype data_i,
  input  logic pop_i,
  output dtype data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  dtype            mem_q [Depth];
  dtype            mem_d [Depth];
  logic            push_en, pop_en;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries data only; validity is tracked by the counter.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/result_queues_stage.sv
// result_queues_stage
//   Lane writeback stage: buffers results from the five functional units in
//   private FIFOs, round-robin arbitrates the FIFO heads into one registered
//   VRF write port and reports each committed write.
//   Ports:
//     clk_i, rst_ni                    clock, asynchronous active-low reset
//     result_req_i / result_gnt_o      per-source handshake
//     result_addr/wdata/be/id_i        per-source result payload
//     vrf_req_o, vrf_addr/wdata/be_o   registered VRF write port
//     vrf_gnt_i                        VRF accepted the write
//     wb_done_valid/src/id_o           committed-write report
//   Build option: define ARA_RESULT_BYPASS_EN to let a transferring source
//   with an empty FIFO compete directly, cutting latency by one cycle.
module result_queues_stage
  import result_queues_stage_pkg::*;
#(
  parameter int unsigned NrLanes    = 0,
  parameter int unsigned QueueDepth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NrResultSrc-1:0] result_req_i,
  input  vaddr_t                 result_addr_i  [NrResultSrc],
  input  elen_t                  result_wdata_i [NrResultSrc],
  input  strb_t                  result_be_i    [NrResultSrc],
  input  vid_t                   result_id_i    [NrResultSrc],
  output logic [NrResultSrc-1:0] result_gnt_o,
  output logic                   vrf_req_o,
  output vaddr_t                 vrf_addr_o,
  output elen_t                  vrf_wdata_o,
  output strb_t                  vrf_be_o,
  input  logic                   vrf_gnt_i,
  output logic                   wb_done_valid_o,
  output result_src_e            wb_done_src_o,
  output vid_t                   wb_done_id_o
);

  if (QueueDepth < 1 || NrLanes > 16) begin : g_cfg_check
    $error("result_queues_stage: QueueDepth must be >= 1 and NrLanes <= 16");
  end

  logic [NrResultSrc-1:0] full, empty, push, fifo_push, pop, cand;
  result_entry_t          in_entry [NrResultSrc];
  result_entry_t          head     [NrResultSrc];
  result_entry_t          win_entry;
  logic [SrcW-1:0]        win_idx, scan;
  logic                   win_found, load;

  logic [SrcW-1:0] rr_q, rr_d;
  logic            vld_q, vld_d;
  result_src_e     src_q, src_d;
  result_entry_t   entry_q, entry_d;

  // Grant depends on occupancy only; held low while reset is asserted.
  assign result_gnt_o = result_req_i & ~full & {NrResultSrc{rst_ni}};
  assign push         = result_gnt_o;

  // ---- Stage 0: per-source FIFOs ----
  for (genvar s = 0; s < NrResultSrc; s++) begin : g_src
    assign in_entry[s] = '{addr:  result_addr_i[s],
                           wdata: result_wdata_i[s],
                           be:    result_be_i[s],
                           id:    result_id_i[s]};
    assign pop[s]      = load & (win_idx == SrcW'(s)) & ~empty[s];
`ifdef ARA_RESULT_BYPASS_EN
    // A bypassed result goes straight to the output register, not the FIFO.
    assign fifo_push[s] = push[s] & ~(load & (win_idx == SrcW'(s)) & empty[s]);
`else
    assign fifo_push[s] = push[s];
`endif

    result_queues_stage_fifo #(
      .Depth (QueueDepth),
      .dtype (result_entry_t)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push[s]),
      .data_i  (in_entry[s]),
      .pop_i   (pop[s]),
      .data_o  (head[s]),
      .full_o  (full[s]),
      .empty_o (empty[s])
    );
  end

`ifdef ARA_RESULT_BYPASS_EN
  assign cand      = ~empty | push;
  assign win_entry = empty[win_idx] ? in_entry[win_idx] : head[win_idx];
`else
  assign cand      = ~empty;
  assign win_entry = head[win_idx];
`endif

  // Round-robin: first candidate at or after rr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    scan      = rr_q;
    for (int i = 0; i < NrResultSrc; i++) begin
      if (!win_found && cand[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
      scan = src_wrap_inc(scan);
    end
  end

  assign load = (~vld_q | vrf_gnt_i) & win_found;

  always_comb begin
    vld_d   = vld_q;
    src_d   = src_q;
    entry_d = entry_q;
    rr_d    = rr_q;
    if (load) begin
      vld_d   = 1'b1;
      src_d   = result_src_e'(win_idx);
      entry_d = win_entry;
      rr_d    = src_wrap_inc(win_idx);
    end else if (vrf_gnt_i) begin
      vld_d   = 1'b0;
    end
  end

  // ---- Stage 1: VRF output register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= 1'b0;
      src_q   <= ResAlu;
      entry_q <= '0;
      rr_q    <= '0;
    end else begin
      vld_q   <= vld_d;
      src_q   <= src_d;
      entry_q <= entry_d;
      rr_q    <= rr_d;
    end
  end

  assign vrf_req_o       = vld_q;
  assign vrf_addr_o      = entry_q.addr;
  assign vrf_wdata_o     = entry_q.wdata;
  assign vrf_be_o        = entry_q.be;
  assign wb_done_valid_o = vld_q & vrf_gnt_i;
  assign wb_done_src_o   = src_q;
  assign wb_done_id_o    = entry_q.id;

endmodule

// File: tb/tb_result_queues_stage.sv
module tb_result_queues_stage;
  import result_queues_stage_pkg::*;

`ifdef ARA_RESULT_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req;
  vaddr_t      addr  [NrResultSrc];
  elen_t       wdata [NrResultSrc];
  strb_t       be    [NrResultSrc];
  vid_t        id    [NrResultSrc];
  logic [4:0]  gnt;
  logic        vrf_req;
  vaddr_t      vrf_addr;
  elen_t       vrf_wdata;
  strb_t       vrf_be;
  logic        vrf_gnt;
  logic        done_v;
  result_src_e done_src;
  vid_t        done_id;

  int n_assert = 0;
  int n_fail   = 0;
  int k;
  int exp_src;
  int gcnt [NrResultSrc];

  always #5 clk = ~clk;

  result_queues_stage #(.NrLanes(0), .QueueDepth(2)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .result_req_i    (req),
    .result_addr_i   (addr),
    .result_wdata_i  (wdata),
    .result_be_i     (be),
    .result_id_i     (id),
    .result_gnt_o    (gnt),
    .vrf_req_o       (vrf_req),
    .vrf_addr_o      (vrf_addr),
    .vrf_wdata_o     (vrf_wdata),
    .vrf_be_o        (vrf_be),
    .vrf_gnt_i       (vrf_gnt),
    .wb_done_valid_o (done_v),
    .wb_done_src_o   (done_src),
    .wb_done_id_o    (done_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_src(input int s, input vaddr_t a, input elen_t w, input strb_t b, input vid_t i);
    addr[s]  = a;
    wdata[s] = w;
    be[s]    = b;
    id[s]    = i;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < NrResultSrc; s++) set_src(s, '0, '0, '0, '0);
    rst_n   = 1'b0;
    vrf_gnt = 1'b1;
    req     = 5'h1F;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_gnt",     gnt, 5'h00);
    chk("rst_vrf_req", vrf_req, 1'b0);
    chk("rst_done",    done_v, 1'b0);
    chk("rst_addr",    vrf_addr, '0);
    chk("rst_wdata",   vrf_wdata, '0);
    chk("rst_id",      done_id, '0);
    cyc();
    rst_n = 1'b1;
    req   = '0;

    // Single ALU result
    cyc();
    set_src(0, 16'h10, 64'hDEAD_BEEF, 8'hFF, 3'd3);
    req = 5'b00001;
    smp();
    chk("t1_gnt_c0", gnt, 5'b00001);
    chk("t1_req_c0", vrf_req, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      req = '0;
      smp();
      chk("t1_vrf_req", vrf_req, (c == LAT));
      chk("t1_done_v",  done_v,  (c == LAT));
      if (c == LAT) begin
        chk("t1_addr",  vrf_addr, 16'h10);
        chk("t1_wdata", vrf_wdata, 64'hDEAD_BEEF);
        chk("t1_be",    vrf_be, 8'hFF);
        chk("t1_id",    done_id, 3'd3);
        chk("t1_src",   done_src, ResAlu);
      end
    end

    // All sources request every cycle; rr is 1 after the ALU write
    cyc();
    for (int s = 0; s < NrResultSrc; s++)
      set_src(s, vaddr_t'(16'h100 + s), elen_t'(64'h1000 + s), strb_t'(8'h01 << s), vid_t'(s));
    req = 5'h1F;
    exp_src = 1;
    for (int s = 0; s < NrResultSrc; s++) gcnt[s] = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (c >= 10 && c < 15)
        for (int s = 0; s < NrResultSrc; s++) if (gnt[s]) gcnt[s]++;
      if (c >= LAT) begin
        chk("t2_vrf_req", vrf_req, 1'b1);
        chk("t2_src",     done_src, exp_src);
        chk("t2_wdata",   vrf_wdata, 64'h1000 + exp_src);
        exp_src = (exp_src == 4) ? 0 : exp_src + 1;
      end
      cyc();
    end
    req = '0;
    for (int s = 0; s < NrResultSrc; s++) chk("t2_gnt_per_5", gcnt[s], 1);
    k = 0;
    smp();
    while (vrf_req && k < 30) begin
      cyc();
      smp();
      k++;
    end
    chk("t2_drain", vrf_req, 1'b0);

    // MFPU pushes 4 results against a 10-cycle stall
    cyc();
    vrf_gnt = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      set_src(1, vaddr_t'(16'h20 + k), elen_t'(64'hA000 + k), 8'h0F, vid_t'(4 + k));
      req[1] = (k < 4);
      smp();
      chk("t3_stall_gnt", gnt[1], (c < 3));
      chk("t3_stall_done", done_v, 1'b0);
      if (c >= LAT) begin
        chk("t3_stall_req",   vrf_req, 1'b1);
        chk("t3_stall_addr",  vrf_addr, 16'h20);
        chk("t3_stall_wdata", vrf_wdata, 64'hA000);
      end
      if (gnt[1]) k++;
      cyc();
    end
    for (int c = 0; c < 5; c++) begin
      vrf_gnt = 1'b1;
      set_src(1, vaddr_t'(16'h20 + k), elen_t'(64'hA000 + k), 8'h0F, vid_t'(4 + k));
      req[1] = (k < 4);
      smp();
      chk("t3_rel_gnt",  gnt[1], (c == 1));
      chk("t3_rel_done", done_v, (c < 4));
      if (c < 4) begin
        chk("t3_rel_id",   done_id, 4 + c);
        chk("t3_rel_addr", vrf_addr, 16'h20 + c);
        chk("t3_rel_src",  done_src, ResMfpu);
      end
      if (gnt[1]) k++;
      cyc();
    end
    req = '0;

    // Reset with SLDU entries buffered; leaves rr at 4 beforehand
    vrf_gnt = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      set_src(3, vaddr_t'(16'h40 + k), elen_t'(64'hB000 + k), 8'hF0, vid_t'(k));
      req[3] = (k < 4);
      smp();
      if (gnt[3]) k++;
      cyc();
    end
    chk("t4_pre_req",  vrf_req, 1'b1);
    chk("t4_pre_full", gnt[3], 1'b0);
    vrf_gnt = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("t4_rst_req",  vrf_req, 1'b0);
    chk("t4_rst_done", done_v, 1'b0);
    chk("t4_rst_gnt",  gnt, 5'h00);
    cyc();
    rst_n = 1'b1;
    req   = '0;
    smp();
    chk("t4_post_req", vrf_req, 1'b0);
    cyc();
    set_src(3, 16'h55, 64'h5555, 8'h33, 3'd1);
    set_src(4, 16'h66, 64'h6666, 8'hCC, 3'd2);
    req = 5'b11000;
    smp();
    chk("t4_gnt_c0", gnt, 5'b11000);
    for (int c = 1; c <= LAT + 2; c++) begin
      cyc();
      req = '0;
      smp();
      chk("t4_vrf_req", vrf_req, (c == LAT || c == LAT + 1));
      if (c == LAT) begin
        chk("t4_first_src",  done_src, ResSldu);
        chk("t4_first_addr", vrf_addr, 16'h55);
        chk("t4_first_id",   done_id, 3'd1);
      end
      if (c == LAT + 1) begin
        chk("t4_second_src",  done_src, ResMasku);
        chk("t4_second_data", vrf_wdata, 64'h6666);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
